// File: rtl/dom_sched_pkg.sv
// Shared definitions for the DOM multiplier scheduler: share width, lane
// defaults, ID type and the helper that extracts one lane's operand share.
package dom_sched_pkg;

    localparam int SHARE_W     = 2;
    localparam int DEF_N_LANES = 4;
    localparam int MAX_LANES   = 8;
    localparam int BUS_W       = SHARE_W * MAX_LANES;

    typedef logic [$clog2(DEF_N_LANES)-1:0] lane_id_t;
    typedef logic [SHARE_W-1:0]             share_t;

    // Operand share of lane 'lane' from a packed bus (lane i at [2i+1:2i]).
    function automatic share_t lane_slice(input logic [BUS_W-1:0] bus, input int lane);
        return bus[lane * SHARE_W +: SHARE_W];
    endfunction

endpackage

// File: rtl/GF22Mult.sv
// GF(2^2) multiplier, polynomial basis with x^2 + x + 1; bit 1 is the x
// coefficient, bit 0 the constant term. Purely combinational.
module GF22Mult (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] q
);

    assign q[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    assign q[0] = (a[1] & b[1]) ^ (a[0] & b[0]);

endmodule

// File: rtl/dom_dep_pipe.sv
// Two-stage DOM-dependent GF(2^2) multiplier with valid/tag sideband.
// Stage 1 registers the partial products after the mask Z has been added
// to the cross-domain terms; stage 2 compresses each domain to one share.
// Data registers only load on valid cycles so idle cycles cause no toggles.
module dom_dep_pipe
    import dom_sched_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [SHARE_W-1:0] ax,
    input  logic [SHARE_W-1:0] ay,
    input  logic [SHARE_W-1:0] az,
    input  logic [SHARE_W-1:0] bx,
    input  logic [SHARE_W-1:0] by,
    input  logic [SHARE_W-1:0] bz,
    input  logic [SHARE_W-1:0] z,
    output logic               out_valid,
    output logic [TAG_W-1:0]   out_tag,
    output logic [SHARE_W-1:0] aq,
    output logic [SHARE_W-1:0] bq,
    output logic               busy
);

    logic [SHARE_W-1:0] t_s;
    logic [SHARE_W-1:0] dep_a_s, dep_b_s, inn_a_s, inn_b_s, ax_bz_s, bx_az_s;
    logic [SHARE_W-1:0] dep_a_r, dep_b_r, inn_a_r, inn_b_r, cross_a_r, cross_b_r;
    logic [TAG_W-1:0]   tag1_r, tag2_r;
    logic               v1_r, v2_r;
    logic [SHARE_W-1:0] aq_r, bq_r;

    assign t_s = ay ^ az ^ by ^ bz;

    GF22Mult u_dep_a (.a(ax), .b(t_s), .q(dep_a_s));
    GF22Mult u_dep_b (.a(bx), .b(t_s), .q(dep_b_s));
    GF22Mult u_inn_a (.a(ax), .b(az),  .q(inn_a_s));
    GF22Mult u_inn_b (.a(bx), .b(bz),  .q(inn_b_s));
    GF22Mult u_crs_a (.a(ax), .b(bz),  .q(ax_bz_s));
    GF22Mult u_crs_b (.a(bx), .b(az),  .q(bx_az_s));

    // Stage 1: capture partial products; cross terms are blinded by Z first.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            tag1_r    <= {TAG_W{1'b0}};
            dep_a_r   <= 2'b00;
            dep_b_r   <= 2'b00;
            inn_a_r   <= 2'b00;
            inn_b_r   <= 2'b00;
            cross_a_r <= 2'b00;
            cross_b_r <= 2'b00;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                tag1_r    <= in_tag;
                dep_a_r   <= dep_a_s;
                dep_b_r   <= dep_b_s;
                inn_a_r   <= inn_a_s;
                inn_b_r   <= inn_b_s;
                cross_a_r <= ax_bz_s ^ z;
                cross_b_r <= bx_az_s ^ z;
            end else begin
                tag1_r    <= tag1_r;
                dep_a_r   <= dep_a_r;
                dep_b_r   <= dep_b_r;
                inn_a_r   <= inn_a_r;
                inn_b_r   <= inn_b_r;
                cross_a_r <= cross_a_r;
                cross_b_r <= cross_b_r;
            end
        end
    end

    // Stage 2: per-domain compression into the output shares.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            tag2_r <= {TAG_W{1'b0}};
            aq_r   <= 2'b00;
            bq_r   <= 2'b00;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                tag2_r <= tag1_r;
                aq_r   <= dep_a_r ^ inn_a_r ^ cross_a_r;
                bq_r   <= dep_b_r ^ inn_b_r ^ cross_b_r;
            end else begin
                tag2_r <= tag2_r;
                aq_r   <= aq_r;
                bq_r   <= bq_r;
            end
        end
    end

    assign out_valid = v2_r;
    assign out_tag   = tag2_r;
    assign aq        = aq_r;
    assign bq        = bq_r;
    assign busy      = v1_r | v2_r;

endmodule

// File: rtl/dom_mult_scheduler.sv
// Round-robin front end sharing one DOM-dependent multiplier between lanes.
// A lane is granted only when a fresh mask Z is available, so a mask is
// never reused; the granted lane's operands feed the two-stage pipe.
module dom_mult_scheduler
    import dom_sched_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int ID_W    = $clog2(N_LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_LANES-1:0]         req,
    input  logic [SHARE_W*N_LANES-1:0] ax,
    input  logic [SHARE_W*N_LANES-1:0] ay,
    input  logic [SHARE_W*N_LANES-1:0] az,
    input  logic [SHARE_W*N_LANES-1:0] bx,
    input  logic [SHARE_W*N_LANES-1:0] by,
    input  logic [SHARE_W*N_LANES-1:0] bz,
    output logic [N_LANES-1:0]         gnt,
    input  logic [SHARE_W-1:0]         rnd,
    input  logic                       rnd_valid,
    output logic                       rnd_ready,
    output logic                       out_valid,
    output logic [ID_W-1:0]            out_id,
    output logic [SHARE_W-1:0]         aq,
    output logic [SHARE_W-1:0]         bq,
    output logic                       busy
);

    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    grant_id_s;
    logic [N_LANES-1:0] gnt_s;
    logic               issue_s;
    logic               found_s;
    int                 dist_s;
    int                 best_dist_s;
    logic [BUS_W-1:0]   ax_ext_s, ay_ext_s, az_ext_s, bx_ext_s, by_ext_s, bz_ext_s;

    // Nothing is granted during reset, so no mask is consumed then.
    assign issue_s = (|req) & rnd_valid & ~rst;

    // Arbiter: pick the requesting lane at the smallest rotated distance from the pointer.
    always_comb begin
        grant_id_s  = {ID_W{1'b0}};
        best_dist_s = N_LANES;
        dist_s      = 0;
        gnt_s       = {N_LANES{1'b0}};
        for (int j = 0; j < N_LANES; j++) begin
            dist_s = (j + N_LANES - int'(ptr_r)) % N_LANES;
            if (req[j] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                grant_id_s  = ID_W'(j);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        found_s = issue_s && (best_dist_s < N_LANES);
        for (int j = 0; j < N_LANES; j++) begin
            gnt_s[j] = found_s && (grant_id_s == ID_W'(j));
        end
    end

    assign gnt       = gnt_s;
    assign rnd_ready = |gnt_s;

    // Round-robin pointer: moves past the granted lane, holds on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {ID_W{1'b0}};
        end else if (found_s) begin
            if (grant_id_s == ID_W'(N_LANES - 1)) begin
                ptr_r <= {ID_W{1'b0}};
            end else begin
                ptr_r <= grant_id_s + ID_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ax_ext_s = BUS_W'(ax);
    assign ay_ext_s = BUS_W'(ay);
    assign az_ext_s = BUS_W'(az);
    assign bx_ext_s = BUS_W'(bx);
    assign by_ext_s = BUS_W'(by);
    assign bz_ext_s = BUS_W'(bz);

    dom_dep_pipe #(.TAG_W(ID_W)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (found_s),
        .in_tag    (grant_id_s),
        .ax        (lane_slice(ax_ext_s, int'(grant_id_s))),
        .ay        (lane_slice(ay_ext_s, int'(grant_id_s))),
        .az        (lane_slice(az_ext_s, int'(grant_id_s))),
        .bx        (lane_slice(bx_ext_s, int'(grant_id_s))),
        .by        (lane_slice(by_ext_s, int'(grant_id_s))),
        .bz        (lane_slice(bz_ext_s, int'(grant_id_s))),
        .z         (rnd),
        .out_valid (out_valid),
        .out_tag   (out_id),
        .aq        (aq),
        .bq        (bq),
        .busy      (busy)
    );

endmodule

// File: tb/tb_dom_mult_scheduler.sv
// Randomized/directed bench for dom_mult_scheduler with a cycle-level
// reference model using table-based GF(4) arithmetic.
module tb_dom_mult_scheduler;
    import dom_sched_pkg::*;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] ax, ay, az, bx, by, bz;
    logic [3:0] gnt;
    logic [1:0] rnd;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       out_valid;
    logic [1:0] out_id;
    logic [1:0] aq, bq;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int       m_ptr;
    logic     m_v1, m_v2;
    logic [1:0] m_aq1, m_bq1, m_prod1;
    lane_id_t m_id1;
    logic [1:0] m_last_aq, m_last_bq, m_last_prod;
    lane_id_t m_last_id;
    logic [1:0] obs_aq[$];
    logic [1:0] obs_x[$];

    dom_mult_scheduler dut (
        .clk(clk), .rst(rst), .req(req),
        .ax(ax), .ay(ay), .az(az), .bx(bx), .by(by), .bz(bz),
        .gnt(gnt), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out_valid(out_valid), .out_id(out_id), .aq(aq), .bq(bq), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(4) multiply via discrete log with generator x (x^2 = x + 1)
    function automatic int glog(input logic [1:0] a);
        return (a == 2'd1) ? 0 : (a == 2'd2) ? 1 : 2;
    endfunction

    function automatic logic [1:0] gexp(input int e);
        return (e % 3 == 0) ? 2'd1 : (e % 3 == 1) ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'd0 || b == 2'd0) return 2'd0;
        return gexp(glog(a) + glog(b));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        ax = 8'($urandom); ay = 8'($urandom); az = 8'($urandom);
        bx = 8'($urandom); by = 8'($urandom); bz = 8'($urandom);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_v1 = 1'b0; m_v2 = 1'b0;
        m_aq1 = 2'd0; m_bq1 = 2'd0; m_prod1 = 2'd0; m_id1 = '0;
        m_last_aq = 2'd0; m_last_bq = 2'd0; m_last_prod = 2'd0; m_last_id = '0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic       e_issue;
        int         e_id;
        logic [3:0] e_gnt;
        logic [1:0] lax, lay, laz, lbx, lby, lbz, t;
        @(negedge clk);
        e_issue = 1'b0;
        e_id    = 0;
        if (!rst && rnd_valid) begin
            for (int k = 0; k < N; k++) begin
                if (!e_issue && req[(m_ptr + k) % N]) begin
                    e_issue = 1'b1;
                    e_id    = (m_ptr + k) % N;
                end
            end
        end
        e_gnt = e_issue ? (4'b0001 << e_id) : 4'b0000;
        chk("gnt", 8'(gnt), 8'(e_gnt));
        chk("rnd_ready", 8'(rnd_ready), 8'(e_issue));
        chk("out_valid", 8'(out_valid), 8'(m_v2));
        chk("out_id", 8'(out_id), 8'(m_last_id));
        chk("aq", 8'(aq), 8'(m_last_aq));
        chk("bq", 8'(bq), 8'(m_last_bq));
        chk("busy", 8'(busy), 8'(m_v1 | m_v2));
        if (out_valid) begin
            chk("aq^bq", 8'(aq ^ bq), 8'(m_last_prod));
            obs_aq.push_back(aq);
            obs_x.push_back(aq ^ bq);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_v2 = m_v1;
            if (m_v1) begin
                m_last_aq = m_aq1; m_last_bq = m_bq1;
                m_last_prod = m_prod1; m_last_id = m_id1;
            end
            m_v1 = e_issue;
            if (e_issue) begin
                lax = ax[2*e_id +: 2]; lay = ay[2*e_id +: 2]; laz = az[2*e_id +: 2];
                lbx = bx[2*e_id +: 2]; lby = by[2*e_id +: 2]; lbz = bz[2*e_id +: 2];
                t = lay ^ laz ^ lby ^ lbz;
                m_aq1   = gmul(lax, t) ^ gmul(lax, laz) ^ gmul(lax, lbz) ^ rnd;
                m_bq1   = gmul(lbx, t) ^ gmul(lbx, lbz) ^ gmul(lbx, laz) ^ rnd;
                m_prod1 = gmul(lax ^ lbx, lay ^ lby);
                m_id1   = lane_id_t'(e_id);
                m_ptr   = (e_id + 1) % N;
            end
        end
        #1;
    endtask

    initial begin
        logic [1:0] base_aq;
        int         n_out;
        // power-up reset
        rst = 1'b1; req = 4'b0000; rnd = 2'b00; rnd_valid = 1'b0;
        rand_ops();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();   // reset-state outputs

        // single request from lane 0 with Z = 10
        req = 4'b0001; rnd_valid = 1'b1; rnd = 2'b10; rand_ops();
        step();
        req = 4'b0000; rand_ops();
        repeat (3) step();

        // sweep every (Ax,Bx,Ay,By) combination on lane 0, one issue per cycle
        for (int v = 0; v < 256; v++) begin
            logic [7:0] vv;
            vv = 8'(v);
            rand_ops();
            ax[1:0] = vv[1:0]; bx[1:0] = vv[3:2];
            ay[1:0] = vv[5:4]; by[1:0] = vv[7:6];
            req = 4'b0001; rnd_valid = 1'b1; rnd = 2'($urandom);
            step();
        end
        req = 4'b0000;
        repeat (3) step();

        // all lanes requesting continuously: rotating grants, gapless out_id
        rst = 1'b1; step(); rst = 1'b0;
        obs_aq.delete(); obs_x.delete();
        for (int c = 0; c < 12; c++) begin
            rand_ops(); req = 4'b1111; rnd_valid = 1'b1; rnd = 2'($urandom);
            step();
        end
        req = 4'b0000;
        repeat (3) step();
        chk("rr_outputs", 8'(obs_aq.size()), 8'd12);

        // mask starvation stall with req=0101
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0101; rnd_valid = 1'b0; rand_ops();
        repeat (3) step();
        rnd_valid = 1'b1; rnd = 2'($urandom);
        step();          // lane 0
        req = 4'b0100; rnd = 2'($urandom);
        step();          // lane 2
        req = 4'b0000;
        repeat (3) step();

        // mask independence: X = 10, Y = 11, fixed blinding shares, Z swept
        obs_aq.delete(); obs_x.delete();
        for (int zz = 0; zz < 4; zz++) begin
            rand_ops();
            ax[1:0] = 2'b01; bx[1:0] = 2'b11;
            ay[1:0] = 2'b10; by[1:0] = 2'b01;
            az[1:0] = 2'b01; bz[1:0] = 2'b10;
            req = 4'b0001; rnd_valid = 1'b1; rnd = 2'(zz);
            step();
        end
        req = 4'b0000;
        repeat (5) step();   // drain, then aq/bq must hold on idle cycles
        n_out = obs_aq.size();
        chk("mask_outputs", 8'(n_out), 8'd4);
        if (n_out == 4) begin
            base_aq = obs_aq[0];
            for (int i = 0; i < 4; i++) begin
                chk("mask_aq_delta", 8'(obs_aq[i] ^ base_aq), 8'(i));
                chk("mask_product", 8'(obs_x[i]), 8'(2'b01));
            end
        end

        // reset one cycle after a grant drops the operation and restarts the pointer
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0100; rnd_valid = 1'b1; rnd = 2'($urandom); rand_ops();
        step();          // lane 2 granted
        req = 4'b0000; rst = 1'b1;
        step();
        rst = 1'b0;
        obs_aq.delete(); obs_x.delete();
        repeat (3) step();
        chk("dropped_op", 8'(obs_aq.size()), 8'd0);
        req = 4'b1010; rnd = 2'($urandom);
        step();          // lane 1 expected after pointer restart
        req = 4'b0000;
        repeat (3) step();

        // random traffic
        for (int c = 0; c < 120; c++) begin
            rand_ops();
            req       = 4'($urandom);
            rnd_valid = (($urandom % 4) != 0);
            rnd       = 2'($urandom);
            rst       = (($urandom % 40) == 0);
            step();
        end
        rst = 1'b0; req = 4'b0000;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
